// File: rtl/g2b_pkg.sv
// g2b_pkg: shared defaults and the Gray-to-binary decode function for g2b_stream.
package g2b_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_ERR_W = 8;
    // Zero upper bits decode to zero, so one 32-bit routine serves every WIDTH.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/g2b_stream_if.sv
// g2b_stream_if: Gray input / binary output stream with jump-error status.
interface g2b_stream_if import g2b_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
);
    logic [WIDTH-1:0] grey_input;
    logic             grey_valid;
    logic             grey_ready;
    logic [WIDTH-1:0] binary_output;
    logic             binary_valid;
    logic             binary_ready;
    logic             jump_error;
    logic [ERR_W-1:0] error_count;
    modport slave (
        input  grey_input, grey_valid, binary_ready,
        output grey_ready, binary_output, binary_valid, jump_error, error_count
    );
    modport master (
        output grey_input, grey_valid, binary_ready,
        input  grey_ready, binary_output, binary_valid, jump_error, error_count
    );
endinterface

// File: rtl/g2b_jump_check.sv
// g2b_jump_check: flags accepted Gray words that differ from the previous one in 2+ bits.
module g2b_jump_check import g2b_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [WIDTH-1:0] word,
    output logic             err,
    output logic [ERR_W-1:0] count
);
    logic [WIDTH-1:0] prev;
    logic             first;
    assign err = accept && !first && ($countones(word ^ prev) > 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= '0;
            first <= 1'b1;
            count <= '0;
        end else if (accept) begin
            prev  <= word;
            first <= 1'b0;
            if (err && count != '1) count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/g2b_stream.sv
// g2b_stream: single-register Gray-to-binary stream decoder.
// Define G2B_JUMP_CHECK_EN to enable illegal-step detection and error counting.
module g2b_stream import g2b_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
) (
    input logic          clk,
    input logic          rst,
    g2b_stream_if.slave  bus
);
    logic             accept;
    logic             err;
    logic [WIDTH-1:0] decoded;
    assign bus.grey_ready = !bus.binary_valid || bus.binary_ready;
    assign accept         = bus.grey_valid && bus.grey_ready && !rst;
    assign decoded        = WIDTH'(gray_to_bin(32'(bus.grey_input)));
`ifdef G2B_JUMP_CHECK_EN
    g2b_jump_check #(.WIDTH(WIDTH), .ERR_W(ERR_W)) u_jump (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .word   (bus.grey_input),
        .err    (err),
        .count  (bus.error_count)
    );
`else
    assign err             = 1'b0;
    assign bus.error_count = {ERR_W{1'b0}};
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.binary_valid  <= 1'b0;
            bus.binary_output <= '0;
            bus.jump_error    <= 1'b0;
        end else if (accept) begin
            bus.binary_valid  <= 1'b1;
            bus.binary_output <= decoded;
            bus.jump_error    <= err;
        end else if (bus.binary_ready) begin
            bus.binary_valid  <= 1'b0;
            bus.jump_error    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_g2b_stream.sv
// tb_g2b_stream: randomized and directed checks of g2b_stream against a behavioural model.
module tb_g2b_stream;
    localparam int W = 4;
`ifdef G2B_JUMP_CHECK_EN
    localparam bit JC = 1'b1;
`else
    localparam bit JC = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] g = '0;
    logic gv = 1'b0;
    logic br = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    bit run = 1'b0;
    g2b_stream_if #(.WIDTH(W), .ERR_W(8)) bus ();
    assign bus.grey_input   = g;
    assign bus.grey_valid   = gv;
    assign bus.binary_ready = br;
    g2b_stream #(.WIDTH(W), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [W-1:0] m_out, m_prev;
    logic m_valid, m_jerr, m_first;
    int m_cnt;

    function automatic logic [W-1:0] dec(input logic [W-1:0] x);
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) b[i] = ^(x >> i);
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 0; m_out = '0; m_jerr = 0; m_cnt = 0; m_first = 1; m_prev = '0;
        end else if (gv && (!m_valid || br)) begin
            m_jerr  = JC && !m_first && $countones(g ^ m_prev) >= 2;
            if (m_jerr && m_cnt < 255) m_cnt++;
            m_out   = dec(g);
            m_valid = 1;
            m_prev  = g;
            m_first = 0;
        end else if (br) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("model_valid", int'(bus.binary_valid), int'(m_valid));
            chk("model_ready", int'(bus.grey_ready), int'(!m_valid || br));
            chk("model_out", int'(bus.binary_output), int'(m_out));
            chk("model_cnt", int'(bus.error_count), m_cnt);
            if (m_valid) chk("model_jerr", int'(bus.jump_error), int'(m_jerr));
        end
    end

    task automatic step(input logic [W-1:0] gi, input logic v, input logic r);
        g = gi; gv = v; br = r;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; gv = 0; br = 0; g = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        logic [W-1:0] last;
        @(posedge clk); #1;
        run = 1;
        do_reset();
        chk("rst_valid", int'(bus.binary_valid), 0);
        chk("rst_out", int'(bus.binary_output), 0);
        chk("rst_cnt", int'(bus.error_count), 0);
        chk("rst_ready", int'(bus.grey_ready), 1);
        step(4'b0010, 1, 1);
        chk("dec_out", int'(bus.binary_output), 3);
        chk("dec_valid", int'(bus.binary_valid), 1);
        chk("dec_jerr", int'(bus.jump_error), 0);
        step(4'b0110, 1, 0);
        chk("bp_ready", int'(bus.grey_ready), 0);
        chk("bp_hold", int'(bus.binary_output), 3);
        step(4'b0110, 1, 1);
        chk("bp_accept", int'(bus.binary_output), 4);
        do_reset();
        step(4'b0000, 1, 1); chk("seq0", int'(bus.binary_output), 0);
        step(4'b0001, 1, 1); chk("seq1", int'(bus.binary_output), 1);
        step(4'b0011, 1, 1); chk("seq2", int'(bus.binary_output), 2);
        step(4'b0010, 1, 1); chk("seq3", int'(bus.binary_output), 3);
        chk("seq_noerr", int'(bus.error_count), 0);
        step(4'b1000, 1, 1);
        chk("jump_out", int'(bus.binary_output), 15);
        chk("jump_err", int'(bus.jump_error), int'(JC));
        chk("jump_cnt", int'(bus.error_count), int'(JC));
        do_reset();
        step(4'b1000, 1, 1);
        chk("wrap15", int'(bus.binary_output), 15);
        chk("wrap15_err", int'(bus.jump_error), 0);
        step(4'b0000, 1, 1);
        chk("wrap0", int'(bus.binary_output), 0);
        chk("wrap0_err", int'(bus.jump_error), 0);
        do_reset();
        for (int i = 0; i < 300; i++) step(i[0] ? 4'b0011 : 4'b0000, 1, 1);
        chk("sat_cnt", int'(bus.error_count), JC ? 255 : 0);
        step(4'b0000, 0, 1);
        last = '0;
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] n;
            case ($urandom_range(0, 3))
                0: n = last;
                1, 2: n = last ^ W'(1 << $urandom_range(0, W - 1));
                default: n = W'($urandom);
            endcase
            rst = ($urandom_range(0, 149) == 0);
            step(n, 1'($urandom), 1'($urandom_range(0, 3) != 0));
            if (gv) last = n;
        end
        rst = 0;
        step('0, 0, 1);
        run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/g2b_stream.md
G2B_STREAM -- requirements
Module: g2b_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the Gray/binary word width (legal range 2..32).
REQ-002 SHALL have parameter ERR_W, default 8, giving the error counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port grey_input, input, WIDTH bits: the Gray-coded word.
REQ-006 SHALL have port grey_valid, input, 1 bit: grey_input is valid.
REQ-007 SHALL have port grey_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port binary_output, output, WIDTH bits: the decoded binary word (registered).
REQ-009 SHALL have port binary_valid, output, 1 bit: binary_output is valid.
REQ-010 SHALL have port binary_ready, input, 1 bit: the downstream consumer accepts binary_output.
REQ-011 SHALL have port jump_error, output, 1 bit: the current output beat followed an illegal Gray step.
REQ-012 SHALL have port error_count, output, ERR_W bits: saturating count of illegal steps.

Function
REQ-013 Decode SHALL be b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1]^g[i] for i=WIDTH-2 down to 0.
REQ-014 The output stage SHALL be a single register; grey_ready = !binary_valid || binary_ready (combinational).
REQ-015 A word SHALL be accepted when grey_valid && grey_ready; its decoded value SHALL appear on binary_output with binary_valid=1 on the next cycle (latency 1).
REQ-016 When binary_valid && binary_ready and no word is accepted, binary_valid SHALL fall to 0 next cycle; binary_output SHALL hold its value.
REQ-017 When a consume and an accept occur in the same cycle, the new word SHALL replace the old one with no bubble.
REQ-018 While binary_valid && !binary_ready, binary_output, jump_error and binary_valid SHALL hold stable.
REQ-019 The jump check SHALL compare each accepted Gray word with the previous accepted one: a Hamming distance of 0 (repeat) or 1 is legal; a distance ≥2 is illegal.
REQ-020 The first word accepted after reset SHALL never be flagged.
REQ-021 Wrap-around (e.g. Gray 1000 → 0000 for WIDTH=4, i.e. binary 15 → 0) SHALL be legal.
REQ-022 On an illegal step, jump_error SHALL be set with that beat's binary_valid, and error_count SHALL increment in the same cycle the output register loads.
REQ-023 error_count SHALL saturate at 2^ERR_W-1.
REQ-024 The previous-word register SHALL update on every accept, legal or not.

Reset
REQ-025 While rst=1, the block SHALL force binary_valid=0, binary_output=0, jump_error=0 and error_count=0, and SHALL set the first-word flag; grey_ready SHALL read 1 after reset.
REQ-026 rst asserted mid-transfer SHALL discard any held output word; no accept SHALL occur in a cycle with rst=1.

Configuration
REQ-027 Macro G2B_JUMP_CHECK_EN defined: REQ-019..REQ-024 SHALL be implemented.
REQ-028 Macro G2B_JUMP_CHECK_EN undefined: jump_error and error_count SHALL be tied to 0, no previous-word register SHALL exist, and the ports SHALL remain present.

Structure
REQ-029 Package g2b_pkg SHALL hold the default WIDTH and ERR_W constants and the gray-to-binary decode function.
REQ-030 The jump check SHALL be sub-module g2b_jump_check (inputs: accept strobe and word; outputs: error strobe and saturating count), instantiated only under G2B_JUMP_CHECK_EN.

Verification (WIDTH=4, ERR_W=8)
REQ-031 Reset: rst=1 for 2 cycles → binary_valid=0, binary_output=0000, error_count=0, grey_ready=1.
REQ-032 Basic decode: grey_input=0010, valid, binary_ready=1 → next cycle binary_output=0011, binary_valid=1, jump_error=0.
REQ-033 Backpressure: output holds 0011 with binary_ready=0, grey_valid with 0110 → grey_ready=0 and output stable; binary_ready=1 → accept, next cycle binary_output=0100.
REQ-034 Sequence and error: Gray 0000, 0001, 0011, 0010 → binary 0, 1, 2, 3, no error; then 1000 → binary 1111 with jump_error=1 and error_count=1.
REQ-035 Wrap: Gray 1000 then 0000 → binary 15 then 0, jump_error=0 on both beats.
REQ-036 Saturation: 300 alternating accepts of 0000/0011 → error_count=255; without G2B_JUMP_CHECK_EN → error_count=0 and jump_error=0 throughout.
